// File: rtl/uart_pkt_pkg.sv
// Shared sync defaults, error/state types and the CRC-8 byte update for the UART frame parser.
// Pure definitions; no timing or flow control of its own.
package uart_pkt_pkg;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CHK     = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } pkt_err_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_CMD     = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CHK     = 3'd5,
        ST_META    = 3'd6,
        ST_DRAIN   = 3'd7
    } parser_state_e;

    // CRC-8, poly 0x07, MSB first, one whole byte per call
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_chk_accum.sv
// Running frame checksum (inverted sum or CRC-8); expected byte valid the cycle after the last en.
// No flow control: accumulates whenever en is high, clear has priority.
module uart_chk_accum
    import uart_pkt_pkg::*;
#(
    parameter int CHK_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] expected
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = 8'h00;
        end else if (en) begin
            acc_d = (CHK_MODE == 1) ? crc8_update(acc_q, data) : acc_q + data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign expected = (CHK_MODE == 1) ? acc_q : ~acc_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC0 SYNC1 CMD LEN PAYLOAD CHK into metadata then buffered payload; meta 1 cycle after CHK.
// Stalls the byte input (rx_byte_ready=0) while metadata or payload wait for their consumer.
module uart_frame_parser
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_PAYLOAD_BYTES = 64,
    parameter int         LEN_BYTES         = 2,
    parameter int         CHK_MODE          = 0,
    parameter int         TIMEOUT_CYCLES    = 100000,
    parameter int         REPORT_ERRORS     = 1,
    parameter logic [7:0] SYNC0             = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1             = SYNC1_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic        rx_byte_ready,
    output logic        pkt_meta_valid,
    input  logic        pkt_meta_ready,
    output logic [7:0]  pkt_cmd,
    output logic [15:0] pkt_length,
    output logic [1:0]  pkt_error,
    output logic [7:0]  pkt_payload_data,
    output logic        pkt_payload_valid,
    output logic        pkt_payload_last,
    input  logic        pkt_payload_ready,
    output logic [15:0] err_count
);

    localparam int              IDXW     = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;
    localparam int              TMOW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0]     MAX_LEN  = 16'(MAX_PAYLOAD_BYTES);
    localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT_CYCLES - 1);

    parser_state_e   state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [15:0]     len_q, len_d;
    pkt_err_e        err_q, err_d;
    logic [15:0]     idx_q, idx_d;
    logic            lenb_q, lenb_d;
    logic [TMOW-1:0] tmo_q, tmo_d;
    logic [15:0]     errcnt_q, errcnt_d;

    logic [7:0]      buf_mem [MAX_PAYLOAD_BYTES];
    logic            buf_we;
    logic            acc_en;
    logic            acc_clear;
    logic [7:0]      chk_exp;
    logic            rx_accept;
    logic            tmo_run;
    logic            fail;
    pkt_err_e        fail_code;
    logic [15:0]     len_new;
    logic [15:0]     len_last;

    assign rx_byte_ready = !rst && (state_q != ST_META) && (state_q != ST_DRAIN);
    assign rx_accept     = rx_byte_valid && rx_byte_ready;
    assign tmo_run       = (state_q == ST_HUNT) || (state_q == ST_CMD) || (state_q == ST_LEN) ||
                           (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign acc_clear     = (state_q == ST_IDLE) || (state_q == ST_HUNT);
    assign len_new       = (LEN_BYTES == 1 || !lenb_q) ? {8'h00, rx_byte} : {rx_byte, len_q[7:0]};
    assign len_last      = len_q - 16'd1;

    uart_chk_accum #(
        .CHK_MODE (CHK_MODE)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .en       (acc_en),
        .data     (rx_byte),
        .expected (chk_exp)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        err_d     = err_q;
        idx_d     = idx_q;
        lenb_d    = lenb_q;
        errcnt_d  = errcnt_q;
        acc_en    = 1'b0;
        buf_we    = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        tmo_d     = (tmo_run && !rx_accept) ? tmo_q + TMOW'(1) : '0;

        case (state_q)
            ST_IDLE: begin
                if (rx_accept && rx_byte == SYNC0) begin
                    state_d = ST_HUNT;
                    cmd_d   = 8'h00;
                    len_d   = 16'h0000;
                end
            end
            ST_HUNT: begin
                if (rx_accept) begin
                    if (rx_byte == SYNC1) begin
                        state_d = ST_CMD;
                    end else if (rx_byte != SYNC0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CMD: begin
                if (rx_accept) begin
                    cmd_d   = rx_byte;
                    acc_en  = 1'b1;
                    lenb_d  = 1'b0;
                    len_d   = 16'h0000;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_accept) begin
                    acc_en = 1'b1;
                    len_d  = len_new;
                    if (LEN_BYTES == 1 || lenb_q) begin
                        if (len_new > MAX_LEN) begin
                            fail      = 1'b1;
                            fail_code = ERR_LEN;
                        end else if (len_new == 16'd0) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_PAYLOAD;
                            idx_d   = 16'd0;
                        end
                    end else begin
                        lenb_d = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_accept) begin
                    buf_we = 1'b1;
                    acc_en = 1'b1;
                    idx_d  = idx_q + 16'd1;
                    if (idx_q == len_last) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_accept) begin
                    if (rx_byte == chk_exp) begin
                        state_d = ST_META;
                        err_d   = ERR_NONE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_CHK;
                    end
                end
            end
            ST_META: begin
                if (pkt_meta_ready) begin
                    if (err_q == ERR_NONE && len_q != 16'd0) begin
                        state_d = ST_DRAIN;
                        idx_d   = 16'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (pkt_payload_ready) begin
                    if (idx_q == len_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A length is only reported once it has been fully received
        if (tmo_run && !rx_accept && tmo_q == TMO_LAST) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
            if (state_q == ST_HUNT || state_q == ST_CMD || state_q == ST_LEN) begin
                len_d = 16'h0000;
            end
        end

        if (fail) begin
            errcnt_d = (errcnt_q == 16'hFFFF) ? errcnt_q : errcnt_q + 16'd1;
            if (REPORT_ERRORS != 0) begin
                state_d = ST_META;
                err_d   = fail_code;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= 8'h00;
            len_q    <= 16'h0000;
            err_q    <= ERR_NONE;
            idx_q    <= 16'h0000;
            lenb_q   <= 1'b0;
            tmo_q    <= '0;
            errcnt_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            lenb_q   <= lenb_d;
            tmo_q    <= tmo_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[idx_q[IDXW-1:0]] <= rx_byte;
        end
    end

    assign pkt_meta_valid    = (state_q == ST_META);
    assign pkt_cmd           = cmd_q;
    assign pkt_length        = len_q;
    assign pkt_error         = err_q;
    assign pkt_payload_valid = (state_q == ST_DRAIN);
    assign pkt_payload_data  = (state_q == ST_DRAIN) ? buf_mem[idx_q[IDXW-1:0]] : 8'h00;
    assign pkt_payload_last  = (state_q == ST_DRAIN) && (idx_q == len_last);
    assign err_count         = errcnt_q;

endmodule
